// File: rtl/bank_bus_if.sv
// Bus-side signal bundle for bank_bus_target: the 6509 cycle inputs, the read drive
// and the write-event stream. The master modport is the bus/consumer side, the slave modport is the target.
`timescale 1ns/1ps
interface bank_bus_if #(
  parameter int AW = 4
) ();
  logic          phi2_6509;
  logic          r_w;
  logic [3:0]    address_bank;
  logic [15:0]   address_cpu;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          data_oe;
  logic          sel;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          overflow;

  modport master (
    output phi2_6509, r_w, address_bank, address_cpu, data_in, wr_ready,
    input  data_out, data_oe, sel, wr_valid, wr_addr, wr_data, overflow
  );

  modport slave (
    input  phi2_6509, r_w, address_bank, address_cpu, data_in, wr_ready,
    output data_out, data_oe, sel, wr_valid, wr_addr, wr_data, overflow
  );
endinterface

// File: rtl/bank_bus_target.sv
// System-clock responder for the banked 6509 bus: one decoded register window.
// Committed writes are also queued in a show-ahead event FIFO.
`timescale 1ns/1ps
module bank_bus_target #(
  parameter logic [3:0]  BANK      = 4'hF,
  parameter logic [15:0] BASE      = 16'hDE00,
  parameter int          AW        = 4,
  parameter int          FIFO_LOG2 = 3
) (
  input  logic     clock,
  input  logic     _reset,
  bank_bus_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int NREG  = 1 << AW;

  typedef enum logic [1:0] {IDLE, READ, WRITE, MISS} state_t;

  state_t state, state_nx;

  logic s1, s2, s3;
  logic vld_p0, vld_p1, armed;
  logic rise, fall, commit;

  logic [AW-1:0] offset_q;
  logic [7:0]    hold;
  logic [7:0]    regs [NREG];

  logic [AW+7:0]        fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] rd_ptr, wr_ptr;
  logic [FIFO_LOG2:0]   count;
  logic                 full, pop, push_ok, overflow_q;

  function automatic logic hit_f(input logic [3:0] bank, input logic [15:0] addr);
    return (bank == BANK) && (addr[15:AW] == BASE[15:AW]) && (addr[15:1] != 15'd0);
  endfunction

  // Synchronizer stage; vld_pN marks when s2 holds a real phi2 sample after reset.
  // armed stays low until phi2 is seen low, so a phi2 already high at release is no rise.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      s1     <= bus.phi2_6509;
      s2     <= s1;
      s3     <= s2;
      vld_p0 <= 1'b1;
      vld_p1 <= vld_p0;
      armed  <= armed | (vld_p1 & ~s2);
    end
  end

  assign rise = armed & s2 & ~s3;
  assign fall = ~s2 & s3;

  // Cycle FSM stage
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rise) begin
          if (hit_f(bus.address_bank, bus.address_cpu))
            state_nx = bus.r_w ? READ : WRITE;
          else
            state_nx = MISS;
        end
      end
      READ, WRITE, MISS: begin
        if (fall) state_nx = IDLE;
      end
    endcase
  end

  assign commit       = (state == WRITE) && fall;
  assign bus.sel      = (state == READ) || (state == WRITE);
  assign bus.data_oe  = (state == READ);
  assign bus.data_out = bus.data_oe ? regs[offset_q] : 8'h00;

  // Address/data capture stage
  always_ff @(posedge clock) begin
    if (state == IDLE && rise) offset_q <= bus.address_cpu[AW-1:0];
    if (state == WRITE)        hold     <= bus.data_in;
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else if (commit) begin
      regs[offset_q] <= hold;
    end
  end

  // Write-event FIFO stage; a pop in the same clock frees the slot for a push into a full FIFO.
  assign full         = count[FIFO_LOG2];
  assign bus.wr_valid = (count != '0);
  assign pop          = bus.wr_valid & bus.wr_ready;
  assign push_ok      = commit & (~full | pop);

  always_ff @(posedge clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= {offset_q, hold};
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (commit & full & ~pop) overflow_q <= 1'b1;
    end
  end

  assign {bus.wr_addr, bus.wr_data} = fifo_mem[rd_ptr];
  assign bus.overflow               = overflow_q;

endmodule

// File: tb/tb_bank_bus_target.sv
// Directed bench for bank_bus_target: 16 system clocks per phi2 cycle, 8 high and 8 low.
`timescale 1ns/1ps
module tb_bank_bus_target;

  logic clock = 1'b0;
  logic _reset;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  bank_bus_if #(.AW(4)) bus ();

  bank_bus_target #(
    .BANK(4'hF), .BASE(16'hDE00), .AW(4), .FIFO_LOG2(3)
  ) dut (
    .clock (clock),
    ._reset(_reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full phi2 cycle. Checks sel/data_oe/data_out at k+1, k+2, j+1, j+2.
  task automatic bus_cycle(input string tag, input logic [3:0] bank, input logic [15:0] addr,
                           input logic rw, input logic [7:0] d, input logic exp_sel,
                           input logic [7:0] exp_rd, input logic pop_commit);
    logic       exp_oe;
    logic [7:0] exp_do;
    exp_oe = exp_sel & rw;
    exp_do = exp_oe ? exp_rd : 8'h00;
    @(negedge clock);
    bus.address_bank = bank;
    bus.address_cpu  = addr;
    bus.r_w          = rw;
    bus.data_in      = d;
    bus.phi2_6509    = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    chk({tag, ".sel_k1"}, bus.sel, 1'b0);
    @(posedge clock); #1;
    chk({tag, ".sel_k2"}, bus.sel, exp_sel);
    chk({tag, ".oe_k2"}, bus.data_oe, exp_oe);
    chk({tag, ".do_k2"}, bus.data_out, exp_do);
    repeat (5) @(posedge clock);
    @(negedge clock);
    bus.phi2_6509 = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    chk({tag, ".oe_j1"}, bus.data_oe, exp_oe);
    chk({tag, ".do_j1"}, bus.data_out, exp_do);
    if (pop_commit) bus.wr_ready = 1'b1;
    @(posedge clock); #1;
    if (pop_commit) bus.wr_ready = 1'b0;
    chk({tag, ".sel_j2"}, bus.sel, 1'b0);
    chk({tag, ".oe_j2"}, bus.data_oe, 1'b0);
    repeat (5) @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ea;
    logic [7:0] ed;
    logic [3:0] bo [6];
    logic [7:0] bd [6];

    bus.phi2_6509 = 1'b0; bus.r_w = 1'b1; bus.address_bank = 4'h0;
    bus.address_cpu = 16'h0000; bus.data_in = 8'h00; bus.wr_ready = 1'b0;
    _reset = 1'b0;

    // Reset state
    repeat (3) @(posedge clock); #1;
    chk("rst.oe", bus.data_oe, 1'b0);
    chk("rst.do", bus.data_out, 8'h00);
    chk("rst.sel", bus.sel, 1'b0);
    chk("rst.wr_valid", bus.wr_valid, 1'b0);
    chk("rst.overflow", bus.overflow, 1'b0);
    @(negedge clock); _reset = 1'b1;
    repeat (4) @(posedge clock); #1;

    // Write then read back
    bus_cycle("wr_de03", 4'hF, 16'hDE03, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0);
    chk("wr_de03.valid", bus.wr_valid, 1'b1);
    chk("wr_de03.addr", bus.wr_addr, 4'h3);
    chk("wr_de03.data", bus.wr_data, 8'hA5);
    bus_cycle("rd_de03", 4'hF, 16'hDE03, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b0);
    chk("rd_de03.valid", bus.wr_valid, 1'b1);

    // Asynchronous reset in the middle of a read
    @(negedge clock);
    bus.address_bank = 4'hF; bus.address_cpu = 16'hDE03; bus.r_w = 1'b1; bus.phi2_6509 = 1'b1;
    repeat (3) @(posedge clock); #1;
    chk("midrd.oe_before", bus.data_oe, 1'b1);
    #2 _reset = 1'b0;
    #1;
    chk("midrd.oe", bus.data_oe, 1'b0);
    chk("midrd.sel", bus.sel, 1'b0);
    chk("midrd.do", bus.data_out, 8'h00);
    chk("midrd.wr_valid", bus.wr_valid, 1'b0);
    @(negedge clock); _reset = 1'b1;
    repeat (4) @(posedge clock); #1;
    chk("midrd.no_rise_high", bus.sel, 1'b0);
    @(negedge clock); bus.phi2_6509 = 1'b0;
    repeat (6) @(posedge clock); #1;
    bus_cycle("rd_after_rst", 4'hF, 16'hDE03, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    chk("rd_after_rst.valid", bus.wr_valid, 1'b0);

    // Decode misses
    bus_cycle("wr_bankE", 4'hE, 16'hDE03, 1'b0, 8'h55, 1'b0, 8'h00, 1'b0);
    chk("wr_bankE.valid", bus.wr_valid, 1'b0);
    bus_cycle("wr_de13", 4'hF, 16'hDE13, 1'b0, 8'h77, 1'b0, 8'h00, 1'b0);
    chk("wr_de13.valid", bus.wr_valid, 1'b0);
    bus_cycle("rd_de03_miss", 4'hF, 16'hDE03, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
    bus_cycle("rd_f0000", 4'hF, 16'h0000, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    bus_cycle("rd_f0001", 4'hF, 16'h0001, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);

    // Overflow: nine writes into an eight-entry FIFO with no consumer
    for (int i = 0; i < 9; i++) begin
      bus_cycle("ovf_wr", 4'hF, 16'hDE00 + 16'(i), 1'b0, 8'h10 + 8'(i), 1'b1, 8'h00, 1'b0);
      chk("ovf_wr.overflow", bus.overflow, (i == 8) ? 1'b1 : 1'b0);
    end
    @(negedge clock); bus.wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_drain.valid", bus.wr_valid, 1'b1);
      chk("ovf_drain.addr", bus.wr_addr, 4'(i));
      chk("ovf_drain.data", bus.wr_data, 8'h10 + 8'(i));
      @(negedge clock);
    end
    chk("ovf_drain.empty", bus.wr_valid, 1'b0);
    chk("ovf_drain.sticky", bus.overflow, 1'b1);
    bus.wr_ready = 1'b0;
    bus_cycle("rd_de08", 4'hF, 16'hDE08, 1'b1, 8'h00, 1'b1, 8'h18, 1'b0);
    bus_cycle("rd_de07", 4'hF, 16'hDE07, 1'b1, 8'h00, 1'b1, 8'h17, 1'b0);

    // Full FIFO with a pop in the commit clock
    @(negedge clock); _reset = 1'b0;
    @(negedge clock); _reset = 1'b1;
    repeat (4) @(posedge clock); #1;
    chk("full.ovf_cleared", bus.overflow, 1'b0);
    for (int i = 0; i < 8; i++)
      bus_cycle("full_wr", 4'hF, 16'hDE00 + 16'(i), 1'b0, 8'h20 + 8'(i), 1'b1, 8'h00, 1'b0);
    bus_cycle("full_wr_pop", 4'hF, 16'hDE0A, 1'b0, 8'h2A, 1'b1, 8'h00, 1'b1);
    chk("full.overflow", bus.overflow, 1'b0);
    @(negedge clock); bus.wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ea = (i < 7) ? 4'(i + 1) : 4'hA;
      ed = (i < 7) ? 8'h21 + 8'(i) : 8'h2A;
      chk("full_drain.valid", bus.wr_valid, 1'b1);
      chk("full_drain.addr", bus.wr_addr, ea);
      chk("full_drain.data", bus.wr_data, ed);
      @(negedge clock);
    end
    chk("full_drain.empty", bus.wr_valid, 1'b0);
    bus.wr_ready = 1'b0;

    // Back-to-back write/read cycles at the 16x ratio
    bo[0] = 4'h1; bd[0] = 8'h3C;
    bo[1] = 4'hF; bd[1] = 8'hC3;
    bo[2] = 4'h4; bd[2] = 8'h00;
    bo[3] = 4'h0; bd[3] = 8'hFF;
    bo[4] = 4'h9; bd[4] = 8'h5A;
    bo[5] = 4'h1; bd[5] = 8'h81;
    for (int i = 0; i < 6; i++) begin
      bus_cycle("b2b_wr", 4'hF, {12'hDE0, bo[i]}, 1'b0, bd[i], 1'b1, 8'h00, 1'b0);
      bus_cycle("b2b_rd", 4'hF, {12'hDE0, bo[i]}, 1'b1, 8'h00, 1'b1, bd[i], 1'b0);
    end
    bus_cycle("b2b_rd_f", 4'hF, 16'hDE0F, 1'b1, 8'h00, 1'b1, 8'hC3, 1'b0);
    bus_cycle("b2b_rd_9", 4'hF, 16'hDE09, 1'b1, 8'h00, 1'b1, 8'h5A, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
